// File: rtl/if_id_pipeline_register.sv
// IF/ID pipeline register: captures PC+4 and the fetched instruction, holds on a
// hazard stall, squashes to NOP bubbles after a redirect, and counts stall/flush events.
module if_id_pipeline_register #(
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 16
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic [31:0]      PCAdder_in,
   input  logic [31:0]      Instruction_in,
   input  logic             Stall,
   input  logic             Flush,
   output logic [31:0]      PCAdder_out,
   output logic [31:0]      Instruction_out,
   output logic             Valid_out,
   output logic             PCWrite_out,
   output logic [CNT_W-1:0] StallCount_out,
   output logic [CNT_W-1:0] FlushCount_out,
   output logic [1:0]       State_out
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      HOLD   = 2'd1,
      SQUASH = 2'd2
   } state_t;

   localparam logic [1:0]       SQ_INIT = 2'(FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   generate
      if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 4) begin : g_bad_cfg
         $error("if_id_pipeline_register: FLUSH_CYCLES=%0d outside 1..4", FLUSH_CYCLES);
      end
   endgenerate

   state_t     state;
   state_t     state_next;
   logic [1:0] sq_cnt;
   logic       do_bubble;
   logic       do_hold;

   // Flush beats the squash countdown, which beats Stall; Rst is applied in the registers.
   assign do_bubble = Flush | (state == SQUASH);
   assign do_hold   = ~do_bubble & Stall;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state <= RUN;
      end else begin
         state <= state_next;
      end
   end

   // sq_cnt holds the bubbles still owed after the current one; leave SQUASH on the last.
   always_comb begin
      state_next = state;
      if (Flush) begin
         state_next = (FLUSH_CYCLES > 1) ? SQUASH : RUN;
      end else if (state == SQUASH) begin
         state_next = (sq_cnt <= 2'd1) ? RUN : SQUASH;
      end else if (Stall) begin
         state_next = HOLD;
      end else begin
         state_next = RUN;
      end
   end

   always_comb begin
      PCWrite_out = Rst | ~(Stall & ~Flush & (state != SQUASH));
      State_out   = state;
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         sq_cnt <= 2'd0;
      end else if (Flush) begin
         sq_cnt <= SQ_INIT;
      end else if (state == SQUASH && sq_cnt != 2'd0) begin
         sq_cnt <= sq_cnt - 2'd1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         PCAdder_out     <= 32'h0000_0000;
         Instruction_out <= 32'h0000_0000;
         Valid_out       <= 1'b0;
      end else if (do_bubble) begin
         PCAdder_out     <= PCAdder_in;
         Instruction_out <= 32'h0000_0000;
         Valid_out       <= 1'b0;
      end else if (!do_hold) begin
         PCAdder_out     <= PCAdder_in;
         Instruction_out <= Instruction_in;
         Valid_out       <= 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         StallCount_out <= '0;
         FlushCount_out <= '0;
      end else begin
         if (do_hold && StallCount_out != '1) begin
            StallCount_out <= StallCount_out + CNT_ONE;
         end
         if (Flush && FlushCount_out != '1) begin
            FlushCount_out <= FlushCount_out + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_if_id_pipeline_register.sv
// Directed bench for the IF/ID register: three instances share stimulus
// (FLUSH_CYCLES=1, FLUSH_CYCLES=3, CNT_W=4) and each task checks the relevant one.
module tb_if_id_pipeline_register;

   localparam logic [1:0] S_RUN = 2'd0, S_HOLD = 2'd1, S_SQUASH = 2'd2;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_in;
   logic [31:0] instr_in;
   logic        stall;
   logic        flush;

   logic [31:0] a_pc, a_instr, b_pc, b_instr, c_pc, c_instr;
   logic        a_valid, a_pcw, b_valid, b_pcw, c_valid, c_pcw;
   logic [15:0] a_scnt, a_fcnt, b_scnt, b_fcnt;
   logic [3:0]  c_scnt, c_fcnt;
   logic [1:0]  a_state, b_state, c_state;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   if_id_pipeline_register #(.FLUSH_CYCLES(1), .CNT_W(16)) u_fc1 (
      .Clk(clk), .Rst(rst), .PCAdder_in(pc_in), .Instruction_in(instr_in),
      .Stall(stall), .Flush(flush), .PCAdder_out(a_pc), .Instruction_out(a_instr),
      .Valid_out(a_valid), .PCWrite_out(a_pcw), .StallCount_out(a_scnt),
      .FlushCount_out(a_fcnt), .State_out(a_state)
   );

   if_id_pipeline_register #(.FLUSH_CYCLES(3), .CNT_W(16)) u_fc3 (
      .Clk(clk), .Rst(rst), .PCAdder_in(pc_in), .Instruction_in(instr_in),
      .Stall(stall), .Flush(flush), .PCAdder_out(b_pc), .Instruction_out(b_instr),
      .Valid_out(b_valid), .PCWrite_out(b_pcw), .StallCount_out(b_scnt),
      .FlushCount_out(b_fcnt), .State_out(b_state)
   );

   if_id_pipeline_register #(.FLUSH_CYCLES(1), .CNT_W(4)) u_cw4 (
      .Clk(clk), .Rst(rst), .PCAdder_in(pc_in), .Instruction_in(instr_in),
      .Stall(stall), .Flush(flush), .PCAdder_out(c_pc), .Instruction_out(c_instr),
      .Valid_out(c_valid), .PCWrite_out(c_pcw), .StallCount_out(c_scnt),
      .FlushCount_out(c_fcnt), .State_out(c_state)
   );

   // Inputs change 1 ns after a rising edge; comb outputs are sampled 1 ns later.
   task automatic set_in(input logic [31:0] pc, input logic [31:0] ins,
                         input logic st, input logic fl);
      pc_in = pc; instr_in = ins; stall = st; flush = fl;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      set_in(32'h0, 32'h0, 1'b0, 1'b0);
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_in(32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1, 1'b1);
      total++; if (a_pcw !== 1'b1) begin bad++; $display("FAIL reset_pcwrite got=%b exp=1", a_pcw); end
      tick(); tick();
      total++; if (a_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", a_pc); end
      total++; if (a_instr !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=0", a_instr); end
      total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", a_valid); end
      total++; if (a_scnt !== 16'h0 || a_fcnt !== 16'h0) begin bad++; $display("FAIL reset_counts got=%h/%h exp=0/0", a_scnt, a_fcnt); end
      total++; if (b_state !== S_RUN) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", b_state, S_RUN); end
      rst = 1'b0;
   endtask

   task automatic test_load();
      set_in(32'd4, 32'h2008_0005, 1'b0, 1'b0);
      total++; if (a_pcw !== 1'b1) begin bad++; $display("FAIL load_pcwrite got=%b exp=1", a_pcw); end
      tick();
      total++; if (a_pc !== 32'd4) begin bad++; $display("FAIL load_pc got=%h exp=%h", a_pc, 32'd4); end
      total++; if (a_instr !== 32'h2008_0005) begin bad++; $display("FAIL load_instr got=%h exp=20080005", a_instr); end
      total++; if (a_valid !== 1'b1) begin bad++; $display("FAIL load_valid got=%b exp=1", a_valid); end
      set_in(32'd8, 32'h8C09_0004, 1'b0, 1'b0);
      tick();
      total++; if (a_pc !== 32'd8 || a_instr !== 32'h8C09_0004) begin bad++; $display("FAIL load2 got=%h/%h exp=8/8c090004", a_pc, a_instr); end
   endtask

   task automatic test_stall();
      for (int i = 0; i < 3; i++) begin
         set_in(32'd12 + 32'(4 * i), 32'h0100_0000 + 32'(i), 1'b1, 1'b0);
         total++; if (a_pcw !== 1'b0) begin bad++; $display("FAIL stall_pcwrite[%0d] got=%b exp=0", i, a_pcw); end
         tick();
         total++; if (a_pc !== 32'd8 || a_instr !== 32'h8C09_0004 || a_valid !== 1'b1) begin
            bad++; $display("FAIL stall_hold[%0d] got=%h/%h/%b exp=8/8c090004/1", i, a_pc, a_instr, a_valid); end
         total++; if (a_state !== S_HOLD) begin bad++; $display("FAIL stall_state[%0d] got=%0d exp=%0d", i, a_state, S_HOLD); end
      end
      total++; if (a_scnt !== 16'd3) begin bad++; $display("FAIL stall_count got=%0d exp=3", a_scnt); end
      set_in(32'd16, 32'h0000_0020, 1'b0, 1'b0);
      total++; if (a_pcw !== 1'b1) begin bad++; $display("FAIL unstall_pcwrite got=%b exp=1", a_pcw); end
      tick();
      total++; if (a_pc !== 32'd16 || a_instr !== 32'h0000_0020 || a_valid !== 1'b1) begin
         bad++; $display("FAIL unstall_load got=%h/%h/%b exp=10/00000020/1", a_pc, a_instr, a_valid); end
      total++; if (a_state !== S_RUN || a_scnt !== 16'd3) begin bad++; $display("FAIL unstall_state got=%0d/%0d exp=0/3", a_state, a_scnt); end
   endtask

   task automatic test_flush_single();
      set_in(32'd20, 32'h1234_5678, 1'b0, 1'b1);
      tick();
      total++; if (a_instr !== 32'h0 || a_valid !== 1'b0 || a_pc !== 32'd20) begin
         bad++; $display("FAIL flush1_bubble got=%h/%h/%b exp=14/0/0", a_pc, a_instr, a_valid); end
      total++; if (a_fcnt !== 16'd1 || a_state !== S_RUN) begin bad++; $display("FAIL flush1_count got=%0d/%0d exp=1/0", a_fcnt, a_state); end
      set_in(32'd24, 32'hAAAA_0001, 1'b0, 1'b0);
      tick();
      total++; if (a_instr !== 32'hAAAA_0001 || a_valid !== 1'b1) begin bad++; $display("FAIL flush1_resume got=%h/%b exp=aaaa0001/1", a_instr, a_valid); end
   endtask

   task automatic test_flush_multi_stall();
      logic [1:0] exp_st [3];
      exp_st[0] = S_SQUASH; exp_st[1] = S_SQUASH; exp_st[2] = S_RUN;
      do_reset();
      set_in(32'd100, 32'hABCD_0001, 1'b0, 1'b0);
      tick();
      for (int i = 0; i < 3; i++) begin
         set_in(32'd104 + 32'(4 * i), 32'h1111_1111, 1'b1, (i == 0));
         total++; if (b_pcw !== 1'b1) begin bad++; $display("FAIL sq3_pcwrite[%0d] got=%b exp=1", i, b_pcw); end
         tick();
         total++; if (b_instr !== 32'h0 || b_valid !== 1'b0 || b_pc !== 32'd104 + 32'(4 * i)) begin
            bad++; $display("FAIL sq3_bubble[%0d] got=%h/%h/%b exp=%h/0/0", i, b_pc, b_instr, b_valid, 32'd104 + 32'(4 * i)); end
         total++; if (b_state !== exp_st[i] || b_scnt !== 16'd0) begin
            bad++; $display("FAIL sq3_state[%0d] got=%0d/%0d exp=%0d/0", i, b_state, b_scnt, exp_st[i]); end
      end
      set_in(32'd116, 32'h3333_3333, 1'b1, 1'b0);
      total++; if (b_pcw !== 1'b0) begin bad++; $display("FAIL sq3_hold_pcwrite got=%b exp=0", b_pcw); end
      tick();
      total++; if (b_state !== S_HOLD || b_scnt !== 16'd1 || b_pc !== 32'd112 || b_valid !== 1'b0) begin
         bad++; $display("FAIL sq3_hold got=%0d/%0d/%h/%b exp=1/1/70/0", b_state, b_scnt, b_pc, b_valid); end
      total++; if (b_fcnt !== 16'd1) begin bad++; $display("FAIL sq3_fcount got=%0d exp=1", b_fcnt); end
   endtask

   task automatic test_flush_restart();
      logic flush_seq [6];
      logic valid_exp [6];
      flush_seq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      valid_exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         set_in(32'd200 + 32'(4 * i), 32'h5500_0000 + 32'(i), 1'b0, flush_seq[i]);
         tick();
         total++; if (b_valid !== valid_exp[i]) begin bad++; $display("FAIL restart_valid[%0d] got=%b exp=%b", i, b_valid, valid_exp[i]); end
      end
      total++; if (b_instr !== 32'h5500_0005 || b_fcnt !== 16'd2) begin
         bad++; $display("FAIL restart_end got=%h/%0d exp=55000005/2", b_instr, b_fcnt); end
   endtask

   task automatic test_flush_stall_and_reset();
      do_reset();
      set_in(32'd300, 32'h7700_0001, 1'b0, 1'b0);
      tick();
      set_in(32'd304, 32'h7700_0002, 1'b1, 1'b1);
      total++; if (a_pcw !== 1'b1) begin bad++; $display("FAIL fs_pcwrite got=%b exp=1", a_pcw); end
      tick();
      total++; if (a_valid !== 1'b0 || a_instr !== 32'h0 || a_scnt !== 16'd0 || a_fcnt !== 16'd1) begin
         bad++; $display("FAIL fs_bubble got=%b/%h/%0d/%0d exp=0/0/0/1", a_valid, a_instr, a_scnt, a_fcnt); end
      total++; if (b_state !== S_SQUASH) begin bad++; $display("FAIL fs_sq_state got=%0d exp=2", b_state); end
      rst = 1'b1;
      set_in(32'd308, 32'h7700_0003, 1'b1, 1'b0);
      total++; if (b_pcw !== 1'b1) begin bad++; $display("FAIL rstsq_pcwrite got=%b exp=1", b_pcw); end
      tick();
      total++; if (b_state !== S_RUN || b_pc !== 32'h0 || b_instr !== 32'h0 || b_valid !== 1'b0 || b_fcnt !== 16'd0) begin
         bad++; $display("FAIL rstsq_clear got=%0d/%h/%h/%b/%0d exp=0/0/0/0/0", b_state, b_pc, b_instr, b_valid, b_fcnt); end
      rst = 1'b0;
      set_in(32'd312, 32'h7700_0004, 1'b0, 1'b0);
      tick();
      total++; if (b_valid !== 1'b1 || b_instr !== 32'h7700_0004) begin
         bad++; $display("FAIL rstsq_nobubble got=%b/%h exp=1/77000004", b_valid, b_instr); end
   endtask

   task automatic test_saturate();
      do_reset();
      set_in(32'd400, 32'h9900_0001, 1'b0, 1'b0);
      tick();
      for (int i = 0; i < 20; i++) begin
         set_in(32'd404, 32'h9900_0002, 1'b1, 1'b0);
         tick();
      end
      total++; if (c_scnt !== 4'hF) begin bad++; $display("FAIL sat_stall4 got=%h exp=f", c_scnt); end
      total++; if (a_scnt !== 16'd20) begin bad++; $display("FAIL sat_stall16 got=%0d exp=20", a_scnt); end
      for (int i = 0; i < 17; i++) begin
         set_in(32'd408, 32'h9900_0003, 1'b0, 1'b1);
         tick();
      end
      total++; if (c_fcnt !== 4'hF || c_scnt !== 4'hF) begin bad++; $display("FAIL sat_flush4 got=%h/%h exp=f/f", c_fcnt, c_scnt); end
      total++; if (a_fcnt !== 16'd17) begin bad++; $display("FAIL sat_flush16 got=%0d exp=17", a_fcnt); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; pc_in = '0; instr_in = '0; stall = 1'b0; flush = 1'b0;
      test_reset();
      test_load();
      test_stall();
      test_flush_single();
      test_flush_multi_stall();
      test_flush_restart();
      test_flush_stall_and_reset();
      test_saturate();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
